data_axi_lite_bridge: RTL
=========================

DATA_AXI_LITE_BRIDGE -- requirements
Module: data_axi_lite_bridge

Interface
REQ-001 Parameter ADDR_W, default 32, is the address width of both the core-side and AXI-side address ports.
REQ-002 Clocking SHALL be one clock, clk; reset SHALL be rst, asynchronous, active-high.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 req  input  1  core-side request valid.
REQ-006 wr  input  1  1 = write, 0 = read.
REQ-007 wstrb  input  4  write byte enables.
REQ-008 addr  input  ADDR_W  request address.
REQ-009 wdata  input  32  write data.
REQ-010 addr_ok  output  1  request accepted this cycle.
REQ-011 data_ok  output  1  one-cycle completion pulse.
REQ-012 rdata  output  32  read data, valid while data_ok=1.
REQ-013 awaddr, awvalid  output  ADDR_W, 1  AXI-lite write-address channel.
REQ-014 awready  input  1  AXI-lite write-address ready.
REQ-015 m_wdata, m_wstrb, wvalid  output  32, 4, 1  AXI-lite write-data channel.
REQ-016 wready  input  1  AXI-lite write-data ready.
REQ-017 bvalid  input  1; bready  output  1  AXI-lite write-response channel (bresp ignored).
REQ-018 araddr, arvalid  output  ADDR_W, 1; arready  input  1  AXI-lite read-address channel.
REQ-019 m_rdata  input  32; rvalid  input  1; rready  output  1  AXI-lite read-data channel (rresp ignored).

Function
REQ-020 FSM states: IDLE, RD_AR, RD_R, WR_AW_W, WR_B, DONE.
REQ-021 addr_ok = req & (state==IDLE), combinational; on addr_ok, wr/addr/wstrb/wdata are latched and the FSM moves to RD_AR (wr=0) or WR_AW_W (wr=1).
REQ-022 At most one transaction is outstanding; req outside IDLE is held off (addr_ok=0).
REQ-023 RD_AR: arvalid=1, araddr=latched addr; on arready, go to RD_R.
REQ-024 RD_R: rready=1; on rvalid, register m_rdata into rdata and go to DONE.
REQ-025 WR_AW_W: awvalid and wvalid both assert on entry; each drops independently on its own ready handshake; the FSM goes to WR_B once both handshakes are done, including when both occur in the same cycle.
REQ-026 WR_B: bready=1; on bvalid, go to DONE.
REQ-027 DONE: data_ok=1 for exactly one cycle, then IDLE; rdata holds its last value otherwise.
REQ-028 Minimum latency, with ready/valid tied high: read is accept at T0, AR handshake at T1, R handshake at T2, data_ok at T3; write is accept at T0, AW+W handshake at T1, B handshake at T2, data_ok at T3.
REQ-029 Addresses pass unmodified, low bits included; alignment is the core's responsibility.
REQ-030 Valid signals, once asserted, stay asserted with stable payload until their handshake, per AXI.

Reset
REQ-031 On rst, the state is IDLE and every output is 0: addr_ok, data_ok, rdata, all valids, bready, rready, and all addresses and data.
REQ-032 Reset mid-transaction abandons it without issuing data_ok; the interconnect is reset concurrently.

Structure
REQ-033 State encodings and the AXI-lite response code constants belong in the shared defines file.
REQ-034 The block is a single flat module with no sub-modules; it instantiates between the core data port and the AXI interconnect.

Verification
REQ-035 Read of 0x1FC0_0010 with all readies=1 and m_rdata=0xDEAD_BEEF: data_ok at T3 with rdata=0xDEAD_BEEF.
REQ-036 Write to 0x0000_0100 with wstrb=0x3 and wdata=0x1234_5678, awready delayed 3 cycles and wready immediate: wvalid drops at T1, awvalid drops at T4, data_ok one cycle after bvalid.
REQ-037 req held high continuously: second addr_ok occurs in the cycle after data_ok, and never more than one transaction is outstanding.
REQ-038 arready held 0 for 5 cycles: arvalid and araddr stay stable for all 5 cycles.
REQ-039 rst asserted while in RD_R: all outputs are 0 immediately (asynchronous), and no data_ok appears after reset release.
REQ-040 Write then read to the same address against a memory model: the read returns the written bytes merged per wstrb.

Source files
------------

// File: rtl/data_axi_lite_bridge_pkg.sv
// Shared definitions for the core-to-AXI-lite data bridge: FSM state encoding
// and AXI-lite response codes.
package data_axi_lite_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_AR   = 3'd1,
    ST_RD_R    = 3'd2,
    ST_WR_AW_W = 3'd3,
    ST_WR_B    = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/data_axi_lite_bridge.sv
// Bridges a single-outstanding core data port (req/addr_ok/data_ok) onto an
// AXI-lite master; one transaction in flight, responses ignored.
module data_axi_lite_bridge
  import data_axi_lite_bridge_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wr,
  input  logic [3:0]        wstrb,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic              bvalid,
  output logic              bready,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [31:0]       m_rdata,
  input  logic              rvalid,
  output logic              rready
);

  state_t            state_r;
  state_t            state_s;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic [3:0]        wstrb_r;
  logic [31:0]       rdata_r;
  logic              aw_pend_r;
  logic              w_pend_r;
  logic              aw_done_s;
  logic              w_done_s;

  // Gated by rst so a request held through reset is not seen as accepted.
  assign addr_ok = req & ~rst & (state_r == ST_IDLE);
  assign data_ok = (state_r == ST_DONE);
  assign rdata   = rdata_r;
  assign awaddr  = addr_r;
  assign araddr  = addr_r;
  assign m_wdata = wdata_r;
  assign m_wstrb = wstrb_r;
  assign awvalid = aw_pend_r;
  assign wvalid  = w_pend_r;
  assign arvalid = (state_r == ST_RD_AR);
  assign rready  = (state_r == ST_RD_R);
  assign bready  = (state_r == ST_WR_B);

  // Next-state logic; a write channel counts as done if already handshaken or handshaking now.
  always_comb begin
    state_s   = state_r;
    aw_done_s = ~aw_pend_r | awready;
    w_done_s  = ~w_pend_r | wready;
    case (state_r)
      ST_IDLE: begin
        if (addr_ok) begin
          state_s = wr ? ST_WR_AW_W : ST_RD_AR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD_AR: begin
        if (arready) state_s = ST_RD_R;
        else         state_s = ST_RD_AR;
      end
      ST_RD_R: begin
        if (rvalid) state_s = ST_DONE;
        else        state_s = ST_RD_R;
      end
      ST_WR_AW_W: begin
        if (aw_done_s && w_done_s) state_s = ST_WR_B;
        else                       state_s = ST_WR_AW_W;
      end
      ST_WR_B: begin
        if (bvalid) state_s = ST_DONE;
        else        state_s = ST_WR_B;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register, request capture and independent AW/W valid tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      addr_r    <= {ADDR_W{1'b0}};
      wdata_r   <= 32'h0000_0000;
      wstrb_r   <= 4'h0;
      aw_pend_r <= 1'b0;
      w_pend_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      if (addr_ok) begin
        addr_r    <= addr;
        wdata_r   <= wdata;
        wstrb_r   <= wstrb;
        aw_pend_r <= wr;
        w_pend_r  <= wr;
      end else begin
        if (aw_pend_r && awready) aw_pend_r <= 1'b0;
        if (w_pend_r && wready)   w_pend_r  <= 1'b0;
      end
    end
  end

  // Read data capture; holds between completions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_r <= 32'h0000_0000;
    end else if ((state_r == ST_RD_R) && rvalid) begin
      rdata_r <= m_rdata;
    end
  end

endmodule
